// File: rtl/mod_ctrl.sv
// Sequencer for a repeated-subtraction modulo datapath (result = a mod b).
// Handles the start/ready handshake, the datapath load strobe, iteration counting and error reporting.
module mod_ctrl #(
   parameter int WIDTH    = 32,
   parameter int MAX_ITER = 1024,
   parameter int CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             err_div0,
   output logic             err_timeout,
   output logic [CNT_W-1:0] iter_count,
   output logic [WIDTH-1:0] dp_a,
   output logic [WIDTH-1:0] dp_b,
   output logic             dp_load,
   input  logic             dp_lt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_next_s;
   logic [CNT_W-1:0] iter_next_s;
   logic             div0_next_s;
   logic             timeout_next_s;
   logic [WIDTH-1:0] dp_a_next_s;
   logic [WIDTH-1:0] dp_b_next_s;

   // Next-state and next-value decode for the sequencer
   always_comb begin
      state_next_s   = state_r;
      iter_next_s    = iter_count;
      div0_next_s    = err_div0;
      timeout_next_s = err_timeout;
      dp_a_next_s    = dp_a;
      dp_b_next_s    = dp_b;
      case (state_r)
         IDLE: begin
            if (start) begin
               iter_next_s    = {CNT_W{1'b0}};
               timeout_next_s = 1'b0;
               if (b_in != {WIDTH{1'b0}}) begin
                  dp_a_next_s  = a_in;
                  dp_b_next_s  = b_in;
                  div0_next_s  = 1'b0;
                  state_next_s = LOAD;
               end else begin
                  // A zero divisor never reaches the datapath.
                  div0_next_s  = 1'b1;
                  state_next_s = DONE;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         LOAD: begin
            state_next_s = RUN;
         end
         RUN: begin
            if (dp_lt) begin
               state_next_s = DONE;
            end else if (iter_count == MAX_CNT) begin
               timeout_next_s = 1'b1;
               state_next_s   = DONE;
            end else begin
               iter_next_s = iter_count + CNT_ONE;
            end
         end
         DONE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register with Moore outputs registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         ready       <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         dp_load     <= 1'b0;
         err_div0    <= 1'b0;
         err_timeout <= 1'b0;
         iter_count  <= {CNT_W{1'b0}};
         dp_a        <= {WIDTH{1'b0}};
         dp_b        <= {WIDTH{1'b0}};
      end else begin
         state_r     <= state_next_s;
         ready       <= (state_next_s == IDLE);
         busy        <= (state_next_s == LOAD) || (state_next_s == RUN);
         done        <= (state_next_s == DONE);
         dp_load     <= (state_next_s == LOAD);
         err_div0    <= div0_next_s;
         err_timeout <= timeout_next_s;
         iter_count  <= iter_next_s;
         dp_a        <= dp_a_next_s;
         dp_b        <= dp_b_next_s;
      end
   end

endmodule
